interp_window: RTL and testbench
================================

INTERP_WINDOW -- requirements
Module: interp_window

Interface
REQ-001 SHALL have parameter N, default 8, interpolation factor (output samples per input step); power of two, 2 to 64.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, sample bitwidth (signed two's complement).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port sreset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port clear  input  1  synchronous flush to EMPTY state.
REQ-006 SHALL have port data_in  input  DATA_WIDTH  upstream low-rate sample.
REQ-007 SHALL have port data_valid  input  1  data_in valid this cycle.
REQ-008 SHALL have port data_ready  output  1  block accepts data_in this cycle.
REQ-009 SHALL have port sample_out  output  DATA_WIDTH  interpolated high-rate sample, registered.
REQ-010 SHALL have port sample_valid  output  1  sample_out valid this cycle, registered; no downstream backpressure.

Function
REQ-011 SHALL accept an input sample only on a cycle where data_valid and data_ready are both 1 (a transfer).
REQ-012 SHALL implement states EMPTY (no stored sample), PRIMED (previous sample stored), INTERP (emitting a segment).
REQ-013 SHALL drive data_ready = 1 in EMPTY and PRIMED and 0 in INTERP, decoded from state only (no combinational path from data_valid).
REQ-014 SHALL, in EMPTY on a transfer, store data_in as prev, go to PRIMED, and emit nothing.
REQ-015 SHALL, in PRIMED on a transfer, store data_in as cur, load accumulator = prev * N, set step = cur - prev (DATA_WIDTH+1 bits signed), clear counter k, and go to INTERP.
REQ-016 SHALL, in INTERP, emit exactly N samples on N consecutive cycles, sample k (k = 0..N-1) = floor((prev*N + k*(cur-prev)) / N), i.e. accumulator arithmetically shifted right by log2(N).
REQ-017 SHALL add step to the accumulator each INTERP cycle; accumulator width DATA_WIDTH+log2(N)+1; no saturation needed since every result lies between prev and cur.
REQ-018 SHALL, after emitting sample k = N-1, copy cur into prev and return to PRIMED in the following cycle.
REQ-019 SHALL produce the first sample (k = 0, equal to prev) with sample_valid = 1 in the cycle after the accepting edge (latency 1 cycle); throughput 1 input per N+1 cycles.
REQ-020 SHALL hold sample_valid = 0 in EMPTY and PRIMED; sample_out holds its last value when sample_valid = 0.
REQ-021 SHALL ignore data_valid while data_ready = 0; no input is lost or queued.
REQ-022 SHALL, on clear = 1, go to EMPTY and drive sample_valid = 0 from the next cycle, discarding prev, cur and any partial segment; clear takes priority over a simultaneous transfer.
REQ-023 SHALL have counter k wrap only via the INTERP-to-PRIMED transition; k never exceeds N-1.

Reset
REQ-024 SHALL, while sreset = 1 (including mid-segment), force state EMPTY and zero prev, cur, accumulator, step, k, sample_out and sample_valid asynchronously.
REQ-025 SHALL drive data_ready = 1 (EMPTY) while in reset; the first transfer after reset deassertion is treated as the EMPTY-state sample.

Structure
REQ-026 SHALL take its state enum type (EMPTY, PRIMED, INTERP) from shared package interp_pkg, which also holds the log2(N) helper constant function.
REQ-027 SHALL be a single module with no sub-modules; the accumulator and counter are inline.

Verification
REQ-028 SHALL cover: N=4, inputs 0 then 100 -> sample_out 0, 25, 50, 75 on four consecutive cycles starting one cycle after the second transfer; data_ready 0 during them.
REQ-029 SHALL cover: N=4, inputs 100 then -100 -> 100, 50, 0, -50; next input 0 -> -100, -75, -50, -25 (prev carried over).
REQ-030 SHALL cover: N=4, inputs 0 then 3 -> 0, 0, 1, 2 (floor rounding); inputs 0 then -3 -> 0, -1, -2, -3.
REQ-031 SHALL cover: data_valid held 1 continuously with an incrementing data_in -> exactly one transfer per N+1 cycles, no values skipped, N samples per transfer.
REQ-032 SHALL cover: clear asserted together with data_valid during the k=2 INTERP cycle -> no further sample_valid, state EMPTY, that input not accepted, and the next input only primes (no output).
REQ-033 SHALL cover: sreset pulsed mid-segment -> sample_valid and sample_out 0 immediately, data_ready 1, and two transfers are needed before output resumes.

Source files
------------

// File: rtl/interp_pkg.sv
// Shared types and constant helpers for the linear interpolation window.
package interp_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    PRIMED = 2'd1,
    INTERP = 2'd2
  } interp_state_t;

  // Ceiling log2, usable in constant expressions for parameter-derived widths.
  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/interp_window_if.sv
// Sample-stream bundle around interp_window: low-rate input handshake and high-rate output.
interface interp_window_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic signed [DATA_WIDTH-1:0] data_in;
  logic                         data_valid;
  logic                         data_ready;
  logic signed [DATA_WIDTH-1:0] sample_out;
  logic                         sample_valid;

  modport master (
    output data_in, data_valid,
    input  data_ready, sample_out, sample_valid
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, sample_out, sample_valid
  );
endinterface

// File: rtl/interp_window.sv
// Linear interpolator: emits N evenly spaced samples between each pair of consecutive inputs.
module interp_window
  import interp_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         sreset,
  input  logic                         clear,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         data_valid,
  output logic                         data_ready,
  output logic signed [DATA_WIDTH-1:0] sample_out,
  output logic                         sample_valid
);

  localparam int unsigned LG = log2(N);
  localparam int unsigned AW = DATA_WIDTH + LG + 1;
  localparam int unsigned SW = DATA_WIDTH + 1;
  localparam logic [LG-1:0] K_LAST = LG'(N - 1);

  interp_state_t               state_q;
  logic signed [DATA_WIDTH-1:0] prev_q;
  logic signed [DATA_WIDTH-1:0] cur_q;
  logic signed [AW-1:0]         acc_q;
  logic signed [SW-1:0]         step_q;
  logic [LG-1:0]                k_q;
  logic signed [DATA_WIDTH-1:0] out_q;
  logic                         valid_q;

  logic signed [AW-1:0] acc_d;
  logic signed [AW-1:0] prev_scaled;
  logic signed [SW-1:0] step_d;

  always_comb begin
    acc_d       = acc_q + AW'(step_q);
    prev_scaled = AW'(prev_q) <<< LG;
    step_d      = SW'(data_in) - SW'(prev_q);
  end

  // Sample k=0 is loaded on the accepting edge so every sample is visible while in INTERP.
  always_ff @(posedge clk or posedge sreset) begin
    if (sreset) begin
      state_q <= EMPTY;
      prev_q  <= '0;
      cur_q   <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      k_q     <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else if (clear) begin
      state_q <= EMPTY;
      prev_q  <= '0;
      cur_q   <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          valid_q <= 1'b0;
          if (data_valid) begin
            prev_q  <= data_in;
            state_q <= PRIMED;
          end
        end
        PRIMED: begin
          valid_q <= 1'b0;
          if (data_valid) begin
            cur_q   <= data_in;
            acc_q   <= prev_scaled;
            step_q  <= step_d;
            k_q     <= '0;
            out_q   <= prev_q;
            valid_q <= 1'b1;
            state_q <= INTERP;
          end
        end
        INTERP: begin
          if (k_q == K_LAST) begin
            prev_q  <= cur_q;
            k_q     <= '0;
            valid_q <= 1'b0;
            state_q <= PRIMED;
          end else begin
            acc_q   <= acc_d;
            out_q   <= DATA_WIDTH'(acc_d >>> LG);
            k_q     <= k_q + LG'(1);
            valid_q <= 1'b1;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= EMPTY;
        end
      endcase
    end
  end

  assign data_ready   = (state_q != INTERP);
  assign sample_out   = out_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_interp_window.sv
// Randomised and directed bench for interp_window against a queue-based interpolation model.
module tb_interp_window;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;

    logic clk;
    logic sreset;
    logic clear;

    interp_window_if #(.DATA_WIDTH(DW)) bus ();

    interp_window #(.N(N), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .sreset       (sreset),
        .clear        (clear),
        .data_in      (bus.data_in),
        .data_valid   (bus.data_valid),
        .data_ready   (bus.data_ready),
        .sample_out   (bus.sample_out),
        .sample_valid (bus.sample_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    longint exp_q[$];
    longint got_q[$];
    bit     have_prev = 1'b0;
    longint prev_v    = 0;
    longint last_out  = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint floor_div(input longint num, input longint den);
        longint q;
        q = num / den;
        if ((num % den != 0) && (num < 0)) q = q - 1;
        return q;
    endfunction

    // Model: outputs are fixed by the accepted input history, independent of the DUT's state.
    always @(negedge clk) begin
        bit exp_ready;
        longint e, cur_v;
        if (sreset) begin
            check("reset_valid", longint'(bus.sample_valid), 0);
            check("reset_out", longint'(bus.sample_out), 0);
            check("reset_ready", longint'(bus.data_ready), 1);
            exp_q.delete();
            have_prev = 1'b0;
            last_out  = 0;
        end else begin
            exp_ready = (exp_q.size() == 0);
            check("ready", longint'(bus.data_ready), longint'(exp_ready));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("valid", longint'(bus.sample_valid), 1);
                check("sample", longint'(bus.sample_out), e);
                last_out = e;
            end else begin
                check("idle_valid", longint'(bus.sample_valid), 0);
                check("hold_out", longint'(bus.sample_out), last_out);
            end
            if (bus.sample_valid) got_q.push_back(longint'(bus.sample_out));
            if (clear) begin
                exp_q.delete();
                have_prev = 1'b0;
            end else if (bus.data_valid && exp_ready) begin
                cur_v = longint'(bus.data_in);
                if (!have_prev) begin
                    prev_v    = cur_v;
                    have_prev = 1'b1;
                end else begin
                    for (int k = 0; k < int'(N); k++)
                        exp_q.push_back(floor_div(prev_v * N + k * (cur_v - prev_v), N));
                    prev_v = cur_v;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input longint v);
        int n;
        n = 0;
        while (!bus.data_ready && n < 200) begin
            tick();
            n++;
        end
        if (!bus.data_ready) begin
            check("send_timeout", 0, 1);
            return;
        end
        bus.data_in    = DW'(v);
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic check_got(input string nm, input int start,
                             input longint e0, input longint e1, input longint e2, input longint e3);
        longint e[4];
        e = '{e0, e1, e2, e3};
        check({nm, "_count"}, longint'(got_q.size()), longint'(start + 4));
        for (int i = 0; i < 4; i++)
            if (start + i < got_q.size()) check(nm, got_q[start + i], e[i]);
    endtask

    initial begin
        int s;
        int transfers;
        longint v;
        bit r;

        sreset = 1'b1;
        clear  = 1'b0;
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        sreset = 1'b0;
        tick();

        // Ramp 0 -> 100
        s = got_q.size();
        send(0);
        send(100);
        check("ready_during_interp", longint'(bus.data_ready), 0);
        repeat (6) tick();
        check_got("ramp_up", s, 0, 25, 50, 75);

        // Descending segment then carried-over previous sample
        pulse_clear();
        s = got_q.size();
        send(100);
        send(-100);
        repeat (6) tick();
        check_got("ramp_down", s, 100, 50, 0, -50);
        s = got_q.size();
        send(0);
        repeat (6) tick();
        check_got("carry_prev", s, -100, -75, -50, -25);

        // Floor rounding both directions
        pulse_clear();
        s = got_q.size();
        send(0);
        send(3);
        repeat (6) tick();
        check_got("floor_pos", s, 0, 0, 1, 2);
        pulse_clear();
        s = got_q.size();
        send(0);
        send(-3);
        repeat (6) tick();
        check_got("floor_neg", s, 0, -1, -2, -3);

        // Continuous valid: one transfer per N+1 cycles once primed
        pulse_clear();
        bus.data_valid = 1'b1;
        v = 1000;
        transfers = 0;
        for (int c = 0; c < 2 + 5 * (int'(N) + 1); c++) begin
            bus.data_in = DW'(v);
            r = bus.data_ready;
            tick();
            if (r) begin
                transfers++;
                v++;
            end
        end
        bus.data_valid = 1'b0;
        check("throughput_transfers", longint'(transfers), 7);
        repeat (6) tick();

        // Clear together with a transfer during the k=2 cycle
        pulse_clear();
        s = got_q.size();
        send(0);
        send(100);
        tick();
        tick();
        clear          = 1'b1;
        bus.data_valid = 1'b1;
        bus.data_in    = DW'(55);
        tick();
        clear          = 1'b0;
        bus.data_valid = 1'b0;
        repeat (4) tick();
        check("clear_count", longint'(got_q.size()), longint'(s + 3));
        check("clear_ready", longint'(bus.data_ready), 1);
        send(77);
        repeat (6) tick();
        check("clear_prime_only", longint'(got_q.size()), longint'(s + 3));
        send(81);
        repeat (6) tick();
        check_got("after_clear", s + 3, 77, 78, 79, 80);

        // Reset mid-segment
        pulse_clear();
        s = got_q.size();
        send(0);
        send(100);
        tick();
        sreset = 1'b1;
        #1;
        check("rst_imm_valid", longint'(bus.sample_valid), 0);
        check("rst_imm_out", longint'(bus.sample_out), 0);
        check("rst_imm_ready", longint'(bus.data_ready), 1);
        @(posedge clk);
        #2;
        sreset = 1'b0;
        check("rst_count", longint'(got_q.size()), longint'(s + 1));
        send(10);
        repeat (6) tick();
        check("rst_prime_only", longint'(got_q.size()), longint'(s + 1));
        send(14);
        repeat (6) tick();
        check_got("after_reset", s + 1, 10, 11, 12, 13);

        // Random traffic with occasional clear and reset
        for (int i = 0; i < 600; i++) begin
            bus.data_valid = 1'($urandom_range(0, 1));
            bus.data_in    = DW'($urandom);
            clear          = ($urandom_range(0, 49) == 0);
            sreset         = ($urandom_range(0, 149) == 0);
            tick();
        end
        sreset         = 1'b0;
        clear          = 1'b0;
        bus.data_valid = 1'b0;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
